// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic stream generator.
package sc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sc_state_e;

    // Right-shift Galois feedback masks giving a maximal-length sequence for each width.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            16:      return 16'hB400;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int sc_len(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_LEN   = sc_len(DEFAULT_WIDTH);

endpackage

// File: rtl/sc_lfsr.sv
// Galois LFSR shared by all channels; load (back to SEED) takes priority over step.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V    = WIDTH'(SEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_V;
        end else if (load) begin
            state <= SEED_V;
        end else if (step) begin
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/sc_stream_gen.sv
// Multi-channel stochastic number generator: one LEN-beat bitstream per latched value.
// Optional SC_DECORR_EN: channel i compares against the LFSR rotated left by i, decorrelating streams.
module sc_stream_gen
    import sc_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int          CHANNELS = 4,
    parameter int unsigned SEED     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_bits,
    output logic                      out_last,
    output logic                      busy
);

    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(sc_len(WIDTH) - 1);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("sc_stream_gen: WIDTH must be in 4..16");
    end
    if ((SEED % (1 << WIDTH)) == 0) begin : g_bad_seed
        $error("sc_stream_gen: SEED must be a nonzero WIDTH-bit value");
    end

    sc_state_e                 state, next_state;
    logic [WIDTH-1:0]          cnt;
    logic [CHANNELS*WIDTH-1:0] values;
    logic [WIDTH-1:0]          lfsr;
    logic                      load, step;

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .state (lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Both ports are valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its data stable until then, and neither side waits on the other's ready combinationally.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    step = 1'b1;
                    if (cnt == LAST_CNT) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            values <= '0;
        end else if (load) begin
            cnt    <= '0;
            values <= in_value;
        end else if (step) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign out_last = out_valid && (cnt == LAST_CNT);

    // LFSR never holds zero, so rnd spans 0..LEN-1 exactly once per period.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] rnd_src;
        logic [WIDTH-1:0] rnd;
        logic [WIDTH-1:0] val;
`ifdef SC_DECORR_EN
        localparam int ROT = i % WIDTH;
        assign rnd_src = (lfsr << ROT) | (lfsr >> (WIDTH - ROT));
`else
        assign rnd_src = lfsr;
`endif
        assign rnd         = rnd_src - WIDTH'(1);
        assign val         = values[i*WIDTH +: WIDTH];
        assign out_bits[i] = (state == RUN) && (rnd < val);
    end

endmodule

// File: tb/tb_sc_stream_gen.sv
// Scoreboard bench for sc_stream_gen: randomized values and stalls against a reference stream model.
module tb_sc_stream_gen;

    localparam int          W    = 8;
    localparam int          CH   = 4;
    localparam int unsigned SEED = 1;
    localparam int          LEN  = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] in_value;
    logic            out_valid;
    logic            out_ready;
    logic [CH-1:0]   out_bits;
    logic            out_last;
    logic            busy;

    sc_stream_gen #(.WIDTH(W), .CHANNELS(CH), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [CH:0]     exp_q[$];
    logic [CH*W-1:0] val_q[$];
    logic            stall_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int lfsr_next(input int s);
        int taps;
        taps = int'(sc_pkg::lfsr_taps(W));
        return (s % 2 == 1) ? ((s / 2) ^ taps) : (s / 2);
    endfunction

    function automatic int rot_left(input int s, input int r);
        return ((s << r) | (s >> (W - r))) & LEN;
    endfunction

    task automatic push_stream(input logic [CH*W-1:0] v);
        int s;
        s = int'(SEED);
        for (int k = 0; k < LEN; k++) begin
            logic [CH-1:0] b;
            for (int i = 0; i < CH; i++) begin
                int val, r;
                val = int'(v[i*W +: W]);
`ifdef SC_DECORR_EN
                r = rot_left(s, i % W);
`else
                r = s;
`endif
                b[i] = ((r - 1) < val);
            end
            exp_q.push_back({(k == LEN - 1), b});
            s = lfsr_next(s);
        end
        val_q.push_back(v);
    endtask

    function automatic logic [CH*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    // ---------------- monitor ----------------
    int            ones[CH];
    int            and_cnt, or_cnt, diff_cnt, beat_idx;
    int            last_and, last_or, last_diff;
    logic          stalled = 1'b0;
    logic [CH-1:0] held_bits;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) ones[i] = 0;
            and_cnt = 0; or_cnt = 0; diff_cnt = 0; beat_idx = 0;
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) check("stall_hold", 32'(out_bits), 32'(held_bits));
            stalled   = out_valid && !out_ready;
            held_bits = out_bits;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_valid), 32'(0));
                end else begin
                    logic [CH:0] e;
                    e = exp_q.pop_front();
                    check("beat", 32'({out_last, out_bits}), 32'(e));
                end
                for (int i = 0; i < CH; i++) ones[i] += int'(out_bits[i]);
                and_cnt  += int'(out_bits[0] & out_bits[1]);
                or_cnt   += int'(out_bits[0] | out_bits[1]);
                diff_cnt += int'(out_bits[0] ^ out_bits[1]);
                beat_idx++;
                if (out_last) begin
                    if (val_q.size() != 0) begin
                        logic [CH*W-1:0] v;
                        v = val_q.pop_front();
                        for (int i = 0; i < CH; i++) begin
                            int val;
                            val = int'(v[i*W +: W]);
                            check("ones_count", 32'(ones[i]), 32'((val < LEN) ? val : LEN));
                        end
                    end
                    check("stream_length", 32'(beat_idx), 32'(LEN));
                    last_and = and_cnt; last_or = or_cnt; last_diff = diff_cnt;
                    for (int i = 0; i < CH; i++) ones[i] = 0;
                    and_cnt = 0; or_cnt = 0; diff_cnt = 0; beat_idx = 0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [CH*W-1:0] v);
        bit ok;
        ok = 1'b0;
        push_stream(v);
        @(posedge clk);
        #1 in_valid = 1'b1; in_value = v;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!out_valid && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_bits", 32'(out_bits), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Boundary values with a free-flowing consumer, then the same under random stalls.
        send(pack4(0, 1, 128, 255));
        wait_idle();
        stall_en = 1'b1;
        send(pack4(0, 1, 128, 255));
        wait_idle();

        // Correlation between channels 0 and 1.
        stall_en = 1'b0;
        send(pack4(64, 128, 7, 200));
        wait_idle();
`ifndef SC_DECORR_EN
        check("corr_and", 32'(last_and), 32'(64));
        check("corr_or", 32'(last_or), 32'(128));
`endif
        send(pack4(100, 100, 100, 100));
        wait_idle();
`ifdef SC_DECORR_EN
        check("decorr_differs", 32'(last_diff != 0), 32'(1));
`else
        check("corr_identical", 32'(last_diff), 32'(0));
`endif

        // Random values with random stalls.
        stall_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            send(pack4($urandom_range(0, LEN), $urandom_range(0, LEN),
                       $urandom_range(0, LEN), $urandom_range(0, LEN)));
            wait_idle();
        end

        // Reset in the middle of a stream, then restart with the same values.
        stall_en = 1'b0;
        begin
            logic [CH*W-1:0] v;
            bit ok;
            v  = pack4(37, 150, 3, 254);
            ok = 1'b0;
            send(v);
            for (int t = 0; t < 1000; t++) begin
                @(negedge clk);
                #1;
                if (beat_idx >= 100) begin ok = 1'b1; break; end
            end
            if (!ok) check("beat100_timeout", 32'(0), 32'(1));
            #2 rst_n = 1'b0;
            #1;
            check("abort_out_valid", 32'(out_valid), 32'(0));
            check("abort_out_bits", 32'(out_bits), 32'(0));
            check("abort_out_last", 32'(out_last), 32'(0));
            check("abort_busy", 32'(busy), 32'(0));
            exp_q.delete();
            val_q.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            check("abort_in_ready", 32'(in_ready), 32'(1));
            check("abort_idle", 32'(out_valid), 32'(0));
            send(v);
            wait_idle();
        end

        // in_valid held high: one accept per stream, next accept one cycle after the last beat.
        begin
            int acc, lasts, acc2_cyc, last1_cyc;
            bit ok;
            logic [CH*W-1:0] v;
            acc = 0; lasts = 0; acc2_cyc = 0; last1_cyc = 0; ok = 1'b0;
            v = pack4($urandom_range(0, LEN), 64, 128, $urandom_range(0, LEN));
            push_stream(v);
            push_stream(v);
            @(posedge clk);
            #1 in_valid = 1'b1; in_value = v;
            for (int t = 0; t < 3000; t++) begin
                @(negedge clk);
                if (in_valid && in_ready) begin
                    acc++;
                    if (acc == 2) acc2_cyc = cyc;
                end
                if (out_valid && out_ready && out_last) begin
                    lasts++;
                    if (lasts == 1) last1_cyc = cyc;
                    if (lasts == 2) begin ok = 1'b1; break; end
                end
            end
            if (!ok) check("hold_timeout", 32'(0), 32'(1));
            @(posedge clk);
            #1 in_valid = 1'b0;
            check("hold_accepts", 32'(acc), 32'(2));
            check("hold_gap", 32'(acc2_cyc - last1_cyc), 32'(1));
            wait_idle();
            check("hold_no_extra", 32'(out_valid), 32'(0));
        end

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
